// File: rtl/nios2_mult_pkg.sv
// Shared definitions for the Nios II pipelined multiply unit.
//   mul_op_e      : operation encodings (low-word MUL and the three high-word forms)
//   PP_*          : index of each partial product in the four-entry partial array
//   op_a_signed() : operand A is treated as two's complement for this op
//   op_b_signed() : operand B is treated as two's complement for this op
//   op_hi_word()  : op returns the upper half of the full product
package nios2_mult_pkg;

    typedef enum logic [1:0] {
        MULOP_MUL    = 2'b00,
        MULOP_MULXSS = 2'b01,
        MULOP_MULXSU = 2'b10,
        MULOP_MULXUU = 2'b11
    } mul_op_e;

    localparam int NUM_PARTIALS = 4;
    localparam int PP_LL = 0;   // a_lo * b_lo
    localparam int PP_LH = 1;   // a_lo * b_hi
    localparam int PP_HL = 2;   // a_hi * b_lo
    localparam int PP_HH = 3;   // a_hi * b_hi

    function automatic logic op_a_signed(input mul_op_e op);
        return (op == MULOP_MULXSS) || (op == MULOP_MULXSU);
    endfunction

    function automatic logic op_b_signed(input mul_op_e op);
        return (op == MULOP_MULXSS);
    endfunction

    // MUL is the only low-word op; its low word is sign-agnostic, so it
    // can run with both operands treated as unsigned.
    function automatic logic op_hi_word(input mul_op_e op);
        return (op != MULOP_MUL);
    endfunction

endpackage

// File: rtl/nios2_mult_pipe_unit_if.sv
// Handshake/data bundle of the multiply unit.
//   in_valid/in_ready, in_op, in_src1, in_src2, in_tag : operand beat
//   out_valid/out_ready, out_result, out_tag           : result beat
// master: the producer/consumer side; slave: the multiply unit.
interface nios2_mult_pipe_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/nios2_mult_partial.sv
// One (HALF_W+1)x(HALF_W+1) signed multiplier with a registered output.
//   clk, reset : clock and synchronous active-high reset (clears p)
//   en         : load enable for the product register
//   a, b       : signed operands
//   p          : registered signed product, 2*HALF_W+2 bits
module nios2_mult_partial #(
    parameter int HALF_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic signed [HALF_W:0]     a,
    input  logic signed [HALF_W:0]     b,
    output logic signed [2*HALF_W+1:0] p
);
    localparam int PW = 2*HALF_W + 2;

    // Widen both operands before multiplying so the product width is explicit.
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;

    assign a_ext = {{(HALF_W+1){a[HALF_W]}}, a};
    assign b_ext = {{(HALF_W+1){b[HALF_W]}}, b};

    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
        end else if (en) begin
            p <= a_ext * b_ext;
        end
    end
endmodule

// File: rtl/nios2_mult_pipe_unit.sv
// Pipelined multiply unit for the Nios II execute/memory path.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears every stage
//   flush : kills every in-flight beat (including one accepted this cycle)
//   bus   : operand/result handshake bundle (slave side)
// S1 registers four half-width partial products, S2 sums them and selects
// the result word, optional S3 registers the result (latency 2 + OUT_REG).
// All stages advance together whenever the output slot is free or drained.
module nios2_mult_pipe_unit
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int OUT_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    nios2_mult_pipe_unit_if.slave  bus
);
    localparam int HALF_W = DATA_W / 2;
    localparam int OPW    = HALF_W + 1;
    localparam int PPW    = 2*HALF_W + 2;
    localparam int SUMW   = 2*DATA_W + 2;

    logic advance;
    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;

    // ---------------- S1: operand split and partial products ----------------
    mul_op_e in_op_e;
    logic    a_sgn;
    logic    b_sgn;
    assign in_op_e = mul_op_e'(bus.in_op);
    assign a_sgn   = op_a_signed(in_op_e);
    assign b_sgn   = op_b_signed(in_op_e);

    // High halves carry an extra top bit holding the sign (or zero);
    // low halves are always non-negative.
    logic signed [OPW-1:0] a_hi, a_lo, b_hi, b_lo;
    assign a_hi = {a_sgn & bus.in_src1[DATA_W-1], bus.in_src1[DATA_W-1:HALF_W]};
    assign a_lo = {1'b0, bus.in_src1[HALF_W-1:0]};
    assign b_hi = {b_sgn & bus.in_src2[DATA_W-1], bus.in_src2[DATA_W-1:HALF_W]};
    assign b_lo = {1'b0, bus.in_src2[HALF_W-1:0]};

    logic signed [OPW-1:0] pp_a [NUM_PARTIALS];
    logic signed [OPW-1:0] pp_b [NUM_PARTIALS];
    logic signed [PPW-1:0] pp   [NUM_PARTIALS];
    logic signed [SUMW-1:0] pp_x [NUM_PARTIALS];

    assign pp_a[PP_LL] = a_lo;  assign pp_b[PP_LL] = b_lo;
    assign pp_a[PP_LH] = a_lo;  assign pp_b[PP_LH] = b_hi;
    assign pp_a[PP_HL] = a_hi;  assign pp_b[PP_HL] = b_lo;
    assign pp_a[PP_HH] = a_hi;  assign pp_b[PP_HH] = b_hi;

    generate
        for (genvar gi = 0; gi < NUM_PARTIALS; gi++) begin : g_partial
            nios2_mult_partial #(.HALF_W(HALF_W)) u_partial (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .a     (pp_a[gi]),
                .b     (pp_b[gi]),
                .p     (pp[gi])
            );
            assign pp_x[gi] = {{(SUMW-PPW){pp[gi][PPW-1]}}, pp[gi]};
        end
    endgenerate

    logic             s1_valid_reg;
    mul_op_e          s1_op_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= MULOP_MUL;
            s1_tag_reg   <= '0;
        end else begin
            if (advance) begin
                s1_op_reg  <= in_op_e;
                s1_tag_reg <= bus.in_tag;
            end
            if (flush) begin
                s1_valid_reg <= 1'b0;
            end else if (advance) begin
                s1_valid_reg <= bus.in_valid;
            end
        end
    end

    // ---------------- S2: adder tree and word select ----------------
    // Two guard bits above 2*DATA_W keep the signed sum exact before truncation.
    logic signed [SUMW-1:0] p_full;
    logic [DATA_W-1:0]      s2_result_next;
    logic [1:0]             unused_p_top;

    assign p_full = (pp_x[PP_HH] <<< DATA_W)
                  + ((pp_x[PP_HL] + pp_x[PP_LH]) <<< HALF_W)
                  + pp_x[PP_LL];
    assign unused_p_top   = p_full[SUMW-1:2*DATA_W];
    assign s2_result_next = op_hi_word(s1_op_reg) ? p_full[2*DATA_W-1:DATA_W]
                                                  : p_full[DATA_W-1:0];

    logic              s2_valid_reg;
    logic [DATA_W-1:0] s2_result_reg;
    logic [TAG_W-1:0]  s2_tag_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_tag_reg    <= '0;
        end else begin
            if (advance) begin
                s2_result_reg <= s2_result_next;
                s2_tag_reg    <= s1_tag_reg;
            end
            if (flush) begin
                s2_valid_reg <= 1'b0;
            end else if (advance) begin
                s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    // ---------------- S3: optional output register ----------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s3_valid_reg;
            logic [DATA_W-1:0] s3_result_reg;
            logic [TAG_W-1:0]  s3_tag_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s3_valid_reg  <= 1'b0;
                    s3_result_reg <= '0;
                    s3_tag_reg    <= '0;
                end else begin
                    if (advance) begin
                        s3_result_reg <= s2_result_reg;
                        s3_tag_reg    <= s2_tag_reg;
                    end
                    if (flush) begin
                        s3_valid_reg <= 1'b0;
                    end else if (advance) begin
                        s3_valid_reg <= s2_valid_reg;
                    end
                end
            end

            assign bus.out_valid  = s3_valid_reg;
            assign bus.out_result = s3_result_reg;
            assign bus.out_tag    = s3_tag_reg;
        end else begin : g_out_direct
            assign bus.out_valid  = s2_valid_reg;
            assign bus.out_result = s2_result_reg;
            assign bus.out_tag    = s2_tag_reg;
        end
    endgenerate
endmodule
